// File: rtl/eq_band_mixer_if.sv
// Bus bundle for eq_band_mixer: sample input, gain-write port and mixed output.
// The master drives samples and gain writes; the slave is the mixer itself.
interface eq_band_mixer_if #(
   parameter int NUM_BANDS = 4,
   parameter int GAIN_W    = 16
);
   logic [NUM_BANDS*24-1:0]  band_in;
   logic                     in_valid;
   logic                     gain_we;
   logic [2:0]               gain_addr;
   logic signed [GAIN_W-1:0] gain_data;
   logic signed [23:0]       audio_out;
   logic                     out_valid;
   logic                     busy;
   logic                     overrun;

   modport master (
      output band_in, in_valid, gain_we, gain_addr, gain_data,
      input  audio_out, out_valid, busy, overrun
   );

   modport slave (
      input  band_in, in_valid, gain_we, gain_addr, gain_data,
      output audio_out, out_valid, busy, overrun
   );
endinterface

// File: rtl/eq_band_mixer.sv
// Serial multiply-accumulate mixer: one band*gain product per cycle, result >>> 14.
// Define EQ_MIX_SATURATE_EN to saturate the output; otherwise it wraps to 24 bits.
module eq_band_mixer #(
   parameter int NUM_BANDS = 4,
   parameter int GAIN_W    = 16
) (
   input  logic           clk,
   input  logic           rst,
   eq_band_mixer_if.slave bus
);
   localparam int ACC_W  = 44;
   localparam int PROD_W = 24 + GAIN_W;
   localparam int IDX_W  = $clog2(NUM_BANDS);
   localparam logic signed [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(16'h4000);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

   state_t                   r_state, w_state_next;
   logic [IDX_W-1:0]         r_idx;
   logic signed [23:0]       r_band [NUM_BANDS];
   logic signed [GAIN_W-1:0] r_gain [NUM_BANDS];
   logic signed [GAIN_W-1:0] r_snap [NUM_BANDS];
   logic signed [ACC_W-1:0]  r_acc;
   logic signed [23:0]       r_audio;
   logic                     r_out_valid;
   logic                     r_overrun;

   logic                     w_accept;
   logic                     w_last;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_acc_next;
   logic signed [23:0]       w_result;

   assign w_accept   = (r_state == S_IDLE) && bus.in_valid;
   assign w_last     = (r_idx == IDX_W'(NUM_BANDS - 1));
   assign w_prod     = r_band[r_idx] * r_snap[r_idx];
   assign w_acc_next = r_acc + ACC_W'(w_prod);

`ifdef EQ_MIX_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(8388607);
   localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(8388608);
   logic signed [ACC_W-1:0] w_shift;

   assign w_shift = w_acc_next >>> 14;

   always_comb begin
      w_result = w_shift[23:0];
      if (w_shift > SAT_MAX)      w_result = 24'sh7FFFFF;
      else if (w_shift < SAT_MIN) w_result = -24'sh800000;
   end
`else
   // Slicing above bit 14 is the floor shift followed by the 24-bit wrap.
   assign w_result = w_acc_next[37:14];
`endif

   // NOTE: every clocked process uses non-blocking assignments so all state
   // updates at an edge see the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // NOTE: next state defaults to the current state first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid) w_state_next = S_ACC;
         S_ACC:   if (w_last)       w_state_next = S_OUT;
         S_OUT:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx       <= '0;
         r_acc       <= '0;
         r_audio     <= '0;
         r_out_valid <= 1'b0;
         r_overrun   <= 1'b0;
         for (int k = 0; k < NUM_BANDS; k++) r_gain[k] <= GAIN_UNITY;
      end else begin
         r_out_valid <= 1'b0;
         r_overrun   <= bus.in_valid && (r_state != S_IDLE);
         for (int k = 0; k < NUM_BANDS; k++)
            if (bus.gain_we && bus.gain_addr == 3'(k)) r_gain[k] <= bus.gain_data;
         if (w_accept) begin
            r_acc <= '0;
            r_idx <= '0;
         end else if (r_state == S_ACC) begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + IDX_W'(1);
            if (w_last) begin
               r_audio     <= w_result;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

   // NOTE: the sample and gain-snapshot arrays carry no reset; they are always
   // loaded on acceptance before being read, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int k = 0; k < NUM_BANDS; k++) begin
            r_band[k] <= bus.band_in[24*k +: 24];
            r_snap[k] <= r_gain[k];
         end
      end
   end

   assign bus.audio_out = r_audio;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench for eq_band_mixer: vector table, corner sequences, random vs model.
// Build with or without EQ_MIX_SATURATE_EN to match the RTL build.
module tb_eq_band_mixer;
   localparam int NB = 4;
   localparam int GW = 16;

   typedef int vec_t [NB];

   typedef struct packed {
      logic [NB-1:0][23:0] band;
      logic [NB-1:0][15:0] gain;
      int                  exp;
   } vec_rec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   model_gain [NB];

   always #5 clk = ~clk;

   eq_band_mixer_if #(.NUM_BANDS(NB), .GAIN_W(GW)) bus ();

   eq_band_mixer #(.NUM_BANDS(NB), .GAIN_W(GW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: exact integer dot product, floor-divide by 2^14, then 24-bit reduce.
   function automatic int ref_mix(input vec_t b, input vec_t g);
      longint acc = 0;
      logic signed [23:0] low;
      for (int k = 0; k < NB; k++) acc += longint'(b[k]) * longint'(g[k]);
      acc = acc >>> 14;
`ifdef EQ_MIX_SATURATE_EN
      if (acc > 8388607)  return 8388607;
      if (acc < -8388608) return -8388608;
      return int'(acc);
`else
      low = acc[23:0];
      return int'(low);
`endif
   endfunction

   function automatic vec_rec_t mk(input int b0, b1, b2, b3, g0, g1, g2, g3, e);
      vec_rec_t r;
      r.band[0] = 24'(b0); r.band[1] = 24'(b1); r.band[2] = 24'(b2); r.band[3] = 24'(b3);
      r.gain[0] = 16'(g0); r.gain[1] = 16'(g1); r.gain[2] = 16'(g2); r.gain[3] = 16'(g3);
      r.exp = e;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_gain(input int addr, input int data);
      logic signed [15:0] d;
      d = 16'(data);
      bus.gain_we   = 1'b1;
      bus.gain_addr = 3'(addr);
      bus.gain_data = d;
      tick();
      bus.gain_we = 1'b0;
      if (addr < NB) model_gain[addr] = int'(d);
   endtask

   task automatic set_bands(input vec_t b);
      for (int k = 0; k < NB; k++) bus.band_in[24*k +: 24] = 24'(b[k]);
   endtask

   // Pulse in_valid with the current band_in, wait (bounded) for out_valid, return to IDLE.
   task automatic run_sample(output int result, output int lat);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat    = 0;
      result = 0;
      for (int c = 1; c <= 20; c++) begin
         if (bus.out_valid) begin
            lat    = c;
            result = int'(bus.audio_out);
            break;
         end
         tick();
      end
      tick();
   endtask

   initial begin
      vec_rec_t tbl [7];
      vec_t     b, g;
      int       res, lat, pulses, val;

      rst           = 1'b1;
      bus.band_in   = '0;
      bus.in_valid  = 1'b0;
      bus.gain_we   = 1'b0;
      bus.gain_addr = '0;
      bus.gain_data = '0;
      for (int k = 0; k < NB; k++) model_gain[k] = 16'h4000;
      repeat (3) tick();
      rst = 1'b0;

      check("reset audio_out", int'(bus.audio_out), 0);
      check("reset out_valid", bus.out_valid, 0);
      check("reset busy", bus.busy, 0);
      check("reset overrun", bus.overrun, 0);

      // Reset gains must be unity without any write.
      b = '{100, 200, 300, 400};
      set_bands(b);
      run_sample(res, lat);
      check("reset-unity gains", res, 1000);

      // Unity gains, full timing profile: busy T+1..T+5, out_valid only at T+5.
      b = '{1000, 2000, -500, 0};
      set_bands(b);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         check($sformatf("busy at T+%0d", c), bus.busy, (c <= 5) ? 1 : 0);
         check($sformatf("out_valid at T+%0d", c), bus.out_valid, (c == 5) ? 1 : 0);
         if (c == 5) check("unity mix value", int'(bus.audio_out), 2500);
         tick();
      end

      tbl[0] = mk(1000, 2000, -500, 0, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 2500);
      tbl[1] = mk(1001, 0, 0, 0, 16'h2000, 16'h4000, 16'h4000, 16'h4000, 500);
      tbl[2] = mk(-1001, 0, 0, 0, 16'h2000, 16'h4000, 16'h4000, 16'h4000, -501);
      tbl[3] = mk(400, 400, 400, 400, 16'h4000, 16'hC000, 16'h2000, 16'h1000, 300);
`ifdef EQ_MIX_SATURATE_EN
      tbl[4] = mk(8388607, 8388607, 8388607, 8388607,
                  16'h4000, 16'h4000, 16'h4000, 16'h4000, 8388607);
      tbl[5] = mk(-8388608, -8388608, -8388608, -8388608,
                  16'h4000, 16'h4000, 16'h4000, 16'h4000, -8388608);
`else
      tbl[4] = mk(8388607, 8388607, 8388607, 8388607,
                  16'h4000, 16'h4000, 16'h4000, 16'h4000, -4);
      tbl[5] = mk(-8388608, -8388608, -8388608, -8388608,
                  16'h4000, 16'h4000, 16'h4000, 16'h4000, 0);
`endif
      tbl[6] = mk(3, 0, 0, 0, 16'h8000, 16'h0000, 16'h0000, 16'h0000, -6);

      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < NB; k++) write_gain(k, int'($signed(tbl[i].gain[k])));
         bus.band_in = tbl[i].band;
         run_sample(res, lat);
         check($sformatf("table[%0d] result", i), res, tbl[i].exp);
         check($sformatf("table[%0d] latency", i), lat, NB + 1);
      end

      for (int k = 0; k < NB; k++) write_gain(k, 16'h4000);

      // Second in_valid two edges after an accepted one is dropped with an overrun pulse.
      b = '{10, 20, 30, 40};
      set_bands(b);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      b = '{1, 1, 1, 1};
      set_bands(b);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("overrun pulse", bus.overrun, 1);
      pulses = 0;
      val    = 0;
      for (int c = 0; c < 10; c++) begin
         if (c == 1) check("overrun one cycle", bus.overrun, 0);
         if (bus.out_valid) begin
            pulses++;
            val = int'(bus.audio_out);
         end
         tick();
      end
      check("overrun out_valid count", pulses, 1);
      check("overrun keeps first sample", val, 100);

      // Reset two cycles into ACC, colliding with in_valid and a gain write.
      write_gain(0, 0);
      b = '{100, 0, 0, 0};
      set_bands(b);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.gain_we   = 1'b1;
      bus.gain_addr = 3'd1;
      bus.gain_data = 16'sd0;
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.gain_we  = 1'b0;
      for (int k = 0; k < NB; k++) model_gain[k] = 16'h4000;
      check("post-reset busy", bus.busy, 0);
      check("post-reset audio_out", int'(bus.audio_out), 0);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.out_valid) pulses++;
         tick();
      end
      check("abandoned sample out_valid", pulses, 0);
      run_sample(res, lat);
      check("gains unity after reset", res, 100);

      // Gain write coincident with accepted in_valid applies from the next sample.
      b = '{0, 4000, 0, 0};
      set_bands(b);
      bus.gain_we   = 1'b1;
      bus.gain_addr = 3'd1;
      bus.gain_data = 16'sd0;
      run_sample(res, lat);
      check("coincident write: old gain", res, 4000);
      bus.gain_we   = 1'b0;
      model_gain[1] = 0;
      run_sample(res, lat);
      check("coincident write: new gain", res, 0);

      // Random gains (including ignored out-of-range addresses) and samples against the model.
      for (int i = 0; i < 40; i++) begin
         int nw;
         nw = $urandom_range(0, 3);
         for (int w = 0; w < nw; w++) begin
            logic signed [15:0] gd;
            gd = 16'($urandom);
            write_gain($urandom_range(0, 7), int'(gd));
         end
         for (int k = 0; k < NB; k++) begin
            logic signed [23:0] bs;
            bs   = 24'($urandom);
            b[k] = int'(bs);
            g[k] = model_gain[k];
         end
         set_bands(b);
         run_sample(res, lat);
         check($sformatf("random[%0d] result", i), res, ref_mix(b, g));
         check($sformatf("random[%0d] latency", i), lat, NB + 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/eq_band_mixer.md
EQ_BAND_MIXER -- requirements
Module: eq_band_mixer

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 4, meaning number of FIR band outputs summed (legal 2..8).
REQ-002 SHALL have parameter GAIN_W, default 16, meaning signed band-gain width in Q2.14 format (0x4000 = unity).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port band_in  input  NUM_BANDS*24  signed 24-bit band samples; band k occupies bits [24k+23:24k].
REQ-006 SHALL have port in_valid  input  1  one-cycle strobe indicating band_in holds a new sample set.
REQ-007 SHALL have port gain_we  input  1  gain write enable.
REQ-008 SHALL have port gain_addr  input  3  band index for the gain write.
REQ-009 SHALL have port gain_data  input  GAIN_W  signed Q2.14 gain value.
REQ-010 SHALL have port audio_out  output  24  signed mixed sample, held between updates.
REQ-011 SHALL have port out_valid  output  1  one-cycle pulse when audio_out updates.
REQ-012 SHALL have port busy  output  1  high while a sample set is being processed.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when in_valid arrives while not IDLE.

Function
REQ-014 SHALL implement the FSM IDLE -> ACC -> OUT -> IDLE; IDLE leaves only on in_valid; ACC lasts exactly NUM_BANDS cycles; OUT lasts one cycle.
REQ-015 SHALL, on in_valid in IDLE, latch all of band_in and a snapshot of all gain registers, and clear the accumulator.
REQ-016 SHALL add one signed product band[k]*gain[k] (24x16 -> 40 bits) per ACC cycle, k = 0..NUM_BANDS-1 in order, into a 44-bit signed accumulator.
REQ-017 SHALL form the result as accumulator arithmetic-shifted right by 14 (truncation toward minus infinity), then reduce it to 24 bits per REQ-026/REQ-027.
REQ-018 SHALL update audio_out and pulse out_valid in OUT; with in_valid at edge T, out_valid SHALL be high during cycle T+NUM_BANDS+1.
REQ-019 SHALL drive busy high in ACC and OUT and low in IDLE.
REQ-020 SHALL ignore in_valid in ACC or OUT, drop that sample, and pulse overrun in the following cycle.
REQ-021 SHALL write gain_data to gain[gain_addr] on gain_we in any state; writes with gain_addr >= NUM_BANDS are ignored.
REQ-022 SHALL use the snapshot gains for the sample in flight; a gain write in the same cycle as an accepted in_valid applies from the next sample.

Reset
REQ-023 SHALL, while rst is high at a clock edge, force the FSM to IDLE; clear audio_out, out_valid, busy, overrun, and the accumulator to 0; and set all gains to 0x4000.
REQ-024 SHALL abandon an in-flight sample when reset is asserted mid-ACC/OUT; no out_valid for that sample.
REQ-025 SHALL give rst priority over in_valid and gain_we in the same cycle.

Configuration
REQ-026 SHALL, when macro EQ_MIX_SATURATE_EN is defined, saturate the shifted result to [-8388608, 8388607].
REQ-027 SHALL, when EQ_MIX_SATURATE_EN is undefined, take the low 24 bits of the shifted result (two's-complement wrap).

Verification
REQ-028 SHALL cover unity gains with bands {1000, 2000, -500, 0} and in_valid at T -> audio_out=2500, out_valid only at T+5, busy high T+1..T+5.
REQ-029 SHALL cover gain[0]=0x2000 with band0=1001 and others 0 -> 500; band0=-1001 -> -501.
REQ-030 SHALL cover unity gains with all bands 0x7FFFFF -> 8388607 with EQ_MIX_SATURATE_EN, and -4 (0xFFFFFC) without it.
REQ-031 SHALL cover a second in_valid 2 cycles after an accepted one -> overrun pulse one cycle later, and a single out_valid carrying the first sample's result.
REQ-032 SHALL cover rst asserted 2 cycles into ACC -> no out_valid, audio_out=0, gains read back as unity on the next sample (bands {100,0,0,0} -> 100).
REQ-033 SHALL cover gain_we (band1, 0x0000) coincident with in_valid, band1=4000 and others 0 -> first output 4000, next identical sample -> 0.
